// File: rtl/axis_vote_pkg.sv
// axis_vote_pkg
//   Shared types and field layout for the N-way AXI-Stream voter.
//   - vote_state_e : voter FSM state encoding
//   - cnt_width()  : width of a vote/presence count for a given channel count
//   - m_axis_tuser layout, LSB first: vote_count[CNT_W-1:0], no_majority_flag, timeout_flag
package axis_vote_pkg;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_VOTE    = 2'd1,
    ST_OUTPUT  = 2'd2
  } vote_state_e;

  localparam int TUSER_CNT_LSB = 0;

  function automatic int cnt_width(input int num_ch);
    return $clog2(num_ch + 1);
  endfunction

  function automatic int tuser_nomaj_bit(input int cnt_w);
    return TUSER_CNT_LSB + cnt_w;
  endfunction

  function automatic int tuser_tmo_bit(input int cnt_w);
    return TUSER_CNT_LSB + cnt_w + 1;
  endfunction

endpackage

// File: rtl/vote_tally.sv
// vote_tally
//   Purely combinational vote counter for the N-way voter.
//   Ports:
//     data        : NUM_CH packed payloads, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//     present     : which channels take part in this vote
//     win_data    : payload of the winning channel
//     win_votes   : number of present channels agreeing with the winner
//     no_majority : 1 when the winner does not hold a strict majority of present channels
module vote_tally
  import axis_vote_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  parameter int  NUM_CH     = 3,
  localparam int CNT_W      = cnt_width(NUM_CH)
) (
  input  logic [NUM_CH*DATA_WIDTH-1:0] data,
  input  logic [NUM_CH-1:0]            present,
  output logic [DATA_WIDTH-1:0]        win_data,
  output logic [CNT_W-1:0]             win_votes,
  output logic                         no_majority
);

  logic [CNT_W-1:0] votes [NUM_CH];
  logic [CNT_W-1:0] present_cnt;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      votes[i] = '0;
      for (int j = 0; j < NUM_CH; j++) begin
        if (present[i] && present[j] &&
            (data[j*DATA_WIDTH +: DATA_WIDTH] == data[i*DATA_WIDTH +: DATA_WIDTH]))
          votes[i] = votes[i] + CNT_W'(1);
      end
    end
  end

  // Strict '>' while scanning upward keeps the lowest index on ties.
  always_comb begin
    win_votes = '0;
    win_data  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (present[i] && (votes[i] > win_votes)) begin
        win_votes = votes[i];
        win_data  = data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    present_cnt = '0;
    for (int i = 0; i < NUM_CH; i++)
      present_cnt = present_cnt + CNT_W'(present[i]);
  end

  // 2*win_votes <= present_cnt, evaluated one bit wider to avoid overflow.
  assign no_majority = ({win_votes, 1'b0} <= {1'b0, present_cnt});

endmodule

// File: rtl/axis_vote_nway.sv
// axis_vote_nway
//   Collects one beat from each of NUM_CH AXI-Stream inputs, votes on the
//   payloads and emits the majority value on a single output stream.
//   Optional timeout closes a round early once at least one beat is held.
//   Build option: define AXIS_VOTE_STATS_EN to add the stat_* counters.
//   Ports:
//     clk, rst          : clock, synchronous active-high reset
//     s_axis_*          : NUM_CH input streams (tdata packed per channel)
//     m_axis_*          : voted output stream
//     m_axis_tuser      : {timeout_flag, no_majority_flag, vote_count}
//     stat_rounds/stat_disagree/stat_timeouts : saturating counters (option only)
//
//   state      | meaning
//   -----------+------------------------------------------------------
//   ST_COLLECT | accept at most one beat per channel into its slot
//   ST_VOTE    | tally slots, register result into output registers
//   ST_OUTPUT  | hold result until m_axis_tready, then clear round
module axis_vote_nway
  import axis_vote_pkg::*;
#(
  parameter int  DATA_WIDTH     = 32,
  parameter int  NUM_CH         = 3,
  parameter int  TIMEOUT_CYCLES = 0,
  localparam int CNT_W          = cnt_width(NUM_CH),
  localparam int USER_W         = CNT_W + 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_CH-1:0]            s_axis_tvalid,
  input  logic [NUM_CH-1:0]            s_axis_tlast,
  output logic [NUM_CH-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]        m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic [USER_W-1:0]            m_axis_tuser
`ifdef AXIS_VOTE_STATS_EN
  ,
  output logic [31:0]                  stat_rounds,
  output logic [31:0]                  stat_disagree,
  output logic [31:0]                  stat_timeouts
`endif
);

  localparam int NOMAJ_BIT = tuser_nomaj_bit(CNT_W);
  localparam int TMO_BIT   = tuser_tmo_bit(CNT_W);
  localparam int TMR_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Loaded on the capture edge, so the capture cycle itself counts as the first.
  localparam logic [TMR_W-1:0] TMR_LOAD =
    TMR_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  vote_state_e state_q, state_d;

  logic [NUM_CH*DATA_WIDTH-1:0] slot_data_q;
  logic [NUM_CH-1:0]            slot_last_q;
  logic [NUM_CH-1:0]            slot_full_q;
  logic [TMR_W-1:0]             tmr_q;
  logic                         tmr_run_q;
  logic                         tmo_q;

  logic [NUM_CH-1:0]     capture;
  logic                  all_full;
  logic                  tmo_hit;
  logic                  out_hs;
  logic [DATA_WIDTH-1:0] win_data;
  logic [CNT_W-1:0]      win_votes;
  logic                  no_majority;
  logic [USER_W-1:0]     user_d;

  assign capture  = (state_q == ST_COLLECT) ? (s_axis_tvalid & ~slot_full_q) : '0;
  assign all_full = &slot_full_q;
  // tmr_run_q is only set by a capture, so a running timer implies a filled slot.
  assign tmo_hit  = (TIMEOUT_CYCLES > 0) && tmr_run_q && (tmr_q == '0);
  assign out_hs   = (state_q == ST_OUTPUT) && m_axis_tready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_COLLECT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_COLLECT: if (all_full || tmo_hit) state_d = ST_VOTE;
      ST_VOTE:    state_d = ST_OUTPUT;
      ST_OUTPUT:  if (m_axis_tready) state_d = ST_COLLECT;
      default:    state_d = ST_COLLECT;
    endcase
  end

  // Gated by rst so both handshake outputs are quiet during reset,
  // before the first reset edge has settled the state register.
  always_comb begin
    s_axis_tready = '0;
    m_axis_tvalid = 1'b0;
    if (!rst) begin
      if (state_q == ST_COLLECT) s_axis_tready = ~slot_full_q;
      if (state_q == ST_OUTPUT)  m_axis_tvalid = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_data_q <= '0;
      slot_last_q <= '0;
      slot_full_q <= '0;
      tmr_q       <= '0;
      tmr_run_q   <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (capture[i]) begin
          slot_data_q[i*DATA_WIDTH +: DATA_WIDTH] <= s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
          slot_last_q[i]                          <= s_axis_tlast[i];
        end
      end
      if (out_hs) begin
        slot_full_q <= '0;
        tmr_q       <= '0;
        tmr_run_q   <= 1'b0;
        tmo_q       <= 1'b0;
      end else begin
        slot_full_q <= slot_full_q | capture;
        if ((TIMEOUT_CYCLES > 0) && (state_q == ST_COLLECT)) begin
          if (!tmr_run_q && (|capture)) begin
            tmr_run_q <= 1'b1;
            tmr_q     <= TMR_LOAD;
          end else if (tmr_run_q && (tmr_q != '0)) begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        // A full round wins over a coincident timeout and is not flagged.
        if ((state_q == ST_COLLECT) && (state_d == ST_VOTE))
          tmo_q <= tmo_hit && !all_full;
      end
    end
  end

  vote_tally #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_CH     (NUM_CH)
  ) u_tally (
    .data        (slot_data_q),
    .present     (slot_full_q),
    .win_data    (win_data),
    .win_votes   (win_votes),
    .no_majority (no_majority)
  );

  always_comb begin
    user_d = '0;
    user_d[TUSER_CNT_LSB +: CNT_W] = win_votes;
    user_d[NOMAJ_BIT]              = no_majority;
    user_d[TMO_BIT]                = tmo_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tdata <= '0;
      m_axis_tlast <= 1'b0;
      m_axis_tuser <= '0;
    end else if (state_q == ST_VOTE) begin
      m_axis_tdata <= win_data;
      m_axis_tlast <= &(slot_last_q | ~slot_full_q);
      m_axis_tuser <= user_d;
    end
  end

`ifdef AXIS_VOTE_STATS_EN
  logic disagree_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      disagree_q    <= 1'b0;
      stat_rounds   <= '0;
      stat_disagree <= '0;
      stat_timeouts <= '0;
    end else begin
      if (state_q == ST_VOTE)
        disagree_q <= (win_votes < CNT_W'($countones(slot_full_q)));
      if (out_hs) begin
        if (stat_rounds != '1)
          stat_rounds <= stat_rounds + 32'd1;
        if (disagree_q && (stat_disagree != '1))
          stat_disagree <= stat_disagree + 32'd1;
        if (m_axis_tuser[TMO_BIT] && (stat_timeouts != '1))
          stat_timeouts <= stat_timeouts + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_axis_vote_nway.sv
// tb_axis_vote_nway
//   Directed bench: instance A (3 channels, timeout 8) and instance B
//   (5 channels, no timeout), both 8-bit payloads, shared clock and reset.
//   Inputs are driven and outputs sampled on the falling edge.
module tb_axis_vote_nway;

  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [3*DW-1:0] a_tdata;
  logic [2:0]      a_tvalid, a_tlast, a_tready;
  logic [DW-1:0]   a_mdata;
  logic            a_mvalid, a_mready, a_mlast;
  logic [3:0]      a_tuser;

  logic [5*DW-1:0] b_tdata;
  logic [4:0]      b_tvalid, b_tlast, b_tready;
  logic [DW-1:0]   b_mdata;
  logic            b_mvalid, b_mready, b_mlast;
  logic [4:0]      b_tuser;

`ifdef AXIS_VOTE_STATS_EN
  logic [31:0] a_st_rounds, a_st_disagree, a_st_timeouts;
  logic [31:0] b_st_rounds, b_st_disagree, b_st_timeouts;
`endif

  axis_vote_nway #(.DATA_WIDTH(DW), .NUM_CH(3), .TIMEOUT_CYCLES(8)) u_dut_a (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (a_tdata),
    .s_axis_tvalid (a_tvalid),
    .s_axis_tlast  (a_tlast),
    .s_axis_tready (a_tready),
    .m_axis_tdata  (a_mdata),
    .m_axis_tvalid (a_mvalid),
    .m_axis_tready (a_mready),
    .m_axis_tlast  (a_mlast),
    .m_axis_tuser  (a_tuser)
`ifdef AXIS_VOTE_STATS_EN
    ,
    .stat_rounds   (a_st_rounds),
    .stat_disagree (a_st_disagree),
    .stat_timeouts (a_st_timeouts)
`endif
  );

  axis_vote_nway #(.DATA_WIDTH(DW), .NUM_CH(5), .TIMEOUT_CYCLES(0)) u_dut_b (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (b_tdata),
    .s_axis_tvalid (b_tvalid),
    .s_axis_tlast  (b_tlast),
    .s_axis_tready (b_tready),
    .m_axis_tdata  (b_mdata),
    .m_axis_tvalid (b_mvalid),
    .m_axis_tready (b_mready),
    .m_axis_tlast  (b_mlast),
    .m_axis_tuser  (b_tuser)
`ifdef AXIS_VOTE_STATS_EN
    ,
    .stat_rounds   (b_st_rounds),
    .stat_disagree (b_st_disagree),
    .stat_timeouts (b_st_timeouts)
`endif
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic a_send(input logic [DW-1:0] d0, d1, d2, input logic [2:0] vmask, last);
    a_tdata  = {d2, d1, d0};
    a_tvalid = vmask;
    a_tlast  = last;
    @(posedge clk);
    @(negedge clk);
    a_tvalid = '0;
  endtask

  task automatic b_send(input logic [5*DW-1:0] d, input logic [4:0] last);
    b_tdata  = d;
    b_tvalid = '1;
    b_tlast  = last;
    @(posedge clk);
    @(negedge clk);
    b_tvalid = '0;
  endtask

  // Counts falling edges until the selected m_axis_tvalid rises (bounded).
  task automatic wait_valid(input bit sel_b, output int cyc);
    cyc = 0;
    while (!(sel_b ? b_mvalid : a_mvalid) && (cyc < 40)) begin
      @(negedge clk);
      cyc++;
    end
    check_val(sel_b ? "b_mvalid_seen" : "a_mvalid_seen", sel_b ? b_mvalid : a_mvalid, 1);
  endtask

  task automatic take(input bit sel_b);
    if (sel_b) b_mready = 1'b1; else a_mready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_mready = 1'b0;
    b_mready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int cyc;
    int n;
    rst = 1'b1;
    a_tdata = '0; a_tvalid = '0; a_tlast = '0; a_mready = 1'b0;
    b_tdata = '0; b_tvalid = '0; b_tlast = '0; b_mready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    check_val("rst_a_tready", a_tready, 3'b000);
    check_val("rst_a_mvalid", a_mvalid, 0);
    check_val("rst_a_mdata",  a_mdata,  0);
    check_val("rst_a_tuser",  a_tuser,  0);
    check_val("rst_a_mlast",  a_mlast,  0);
    check_val("rst_b_tready", b_tready, 5'b00000);
    check_val("rst_b_mvalid", b_mvalid, 0);

    rst = 1'b0;
    #1;
    check_val("post_rst_a_tready", a_tready, 3'b111);
    check_val("post_rst_b_tready", b_tready, 5'b11111);
    @(negedge clk);

    // 0xA,0xA,0xB together: 2-of-3 majority, result two edges after capture
    a_send(8'h0A, 8'h0A, 8'h0B, 3'b111, 3'b111);
    check_val("a1_tready_full", a_tready, 3'b000);
    wait_valid(0, cyc);
    check_val("a1_latency", cyc, 2);
    check_val("a1_mdata", a_mdata, 8'h0A);
    check_val("a1_tuser", a_tuser, 4'b0010);
    check_val("a1_mlast", a_mlast, 1);

    // Backpressure for 10 cycles with fresh beats offered on every channel
    a_tdata  = {8'h77, 8'h77, 8'h77};
    a_tvalid = 3'b111;
    repeat (10) begin
      @(negedge clk);
      check_val("hold_mvalid", a_mvalid, 1);
      check_val("hold_mdata",  a_mdata,  8'h0A);
      check_val("hold_tready", a_tready, 3'b000);
    end
    check_val("hold_tuser", a_tuser, 4'b0010);
    a_tvalid = '0;
    take(0);
    check_val("a1_after_hs_mvalid", a_mvalid, 0);
    check_val("a1_after_hs_tready", a_tready, 3'b111);

    // Unanimous round, tlast AND clears when one channel lacks last
    a_send(8'h05, 8'h05, 8'h05, 3'b111, 3'b011);
    wait_valid(0, cyc);
    check_val("a2_latency", cyc, 2);
    check_val("a2_mdata", a_mdata, 8'h05);
    check_val("a2_tuser", a_tuser, 4'b0011);
    check_val("a2_mlast", a_mlast, 0);
    take(0);

    // Timeout: ch0, ch1 send 0x5, ch2 idle; VOTE entered 8 cycles after
    // capture, output valid one edge later
    a_send(8'h05, 8'h05, 8'h00, 3'b011, 3'b011);
    check_val("tmo_tready", a_tready, 3'b100);
    wait_valid(0, cyc);
    check_val("tmo_latency", cyc, 9);
    check_val("tmo_mdata", a_mdata, 8'h05);
    check_val("tmo_tuser", a_tuser, 4'b1010);
    check_val("tmo_mlast", a_mlast, 1);
    take(0);

    // Capture on the same edge as the timeout is still counted
    a_send(8'h09, 8'h00, 8'h00, 3'b001, 3'b000);
    repeat (7) @(negedge clk);
    check_val("tmo_cap_tready", a_tready, 3'b110);
    a_tdata  = {8'h09, 8'h00, 8'h00};
    a_tvalid = 3'b100;
    a_tlast  = 3'b100;
    @(posedge clk);
    @(negedge clk);
    a_tvalid = '0;
    wait_valid(0, cyc);
    check_val("tmo_cap_latency", cyc, 1);
    check_val("tmo_cap_mdata", a_mdata, 8'h09);
    check_val("tmo_cap_tuser", a_tuser, 4'b1010);
    check_val("tmo_cap_mlast", a_mlast, 0);
    take(0);

`ifdef AXIS_VOTE_STATS_EN
    check_val("a_stat_rounds_4",   a_st_rounds,   4);
    check_val("a_stat_disagree_4", a_st_disagree, 1);
    check_val("a_stat_timeouts_4", a_st_timeouts, 2);
`endif

    // Reset with two of three slots filled discards the round
    a_send(8'h01, 8'h01, 8'h00, 3'b011, 3'b011);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("midrst_tready", a_tready, 3'b111);
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (a_mvalid) n++;
    end
    check_val("midrst_no_output", n, 0);

    a_send(8'h3C, 8'h3D, 8'h3C, 3'b111, 3'b111);
    wait_valid(0, cyc);
    check_val("a3_latency", cyc, 2);
    check_val("a3_mdata", a_mdata, 8'h3C);
    check_val("a3_tuser", a_tuser, 4'b0010);
    take(0);

    // Five channels, all distinct: channel 0 wins with one vote, no majority
    b_send({8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 5'b11111);
    wait_valid(1, cyc);
    check_val("b1_latency", cyc, 2);
    check_val("b1_mdata", b_mdata, 8'd1);
    check_val("b1_tuser", b_tuser, 5'b01001);
    check_val("b1_mlast", b_mlast, 1);
    take(1);

    // ch0..4 = 7,9,9,7,7: 7 holds 3 of 5
    b_send({8'd7, 8'd7, 8'd9, 8'd9, 8'd7}, 5'b11111);
    wait_valid(1, cyc);
    check_val("b2_mdata", b_mdata, 8'd7);
    check_val("b2_tuser", b_tuser, 5'b00011);
    take(1);

    // ch0..4 = 9,7,7,9,3: tie at 2 votes, lowest index (ch0 = 9) wins
    b_send({8'd3, 8'd9, 8'd7, 8'd7, 8'd9}, 5'b10111);
    wait_valid(1, cyc);
    check_val("b3_mdata", b_mdata, 8'd9);
    check_val("b3_tuser", b_tuser, 5'b01010);
    check_val("b3_mlast", b_mlast, 0);
    take(1);
    check_val("b3_after_hs_tready", b_tready, 5'b11111);

`ifdef AXIS_VOTE_STATS_EN
    // The mid-round reset cleared the counters on both instances
    check_val("a_stat_rounds",   a_st_rounds,   1);
    check_val("a_stat_disagree", a_st_disagree, 1);
    check_val("a_stat_timeouts", a_st_timeouts, 0);
    check_val("b_stat_rounds",   b_st_rounds,   3);
    check_val("b_stat_disagree", b_st_disagree, 3);
    check_val("b_stat_timeouts", b_st_timeouts, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
